// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: shared widths, opcode encodings and sequencer state
// encodings for the alu issue stage and its neighbours.
package alu_issue_stage_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_OPCODE_SIZE   = 5;
  localparam int DEF_REG_ADDR_SIZE = 3;
  localparam int DEF_IMM_SIZE      = 8;

  localparam logic [DEF_OPCODE_SIZE-1:0] OP_NOT  = 5'd0;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_AND  = 5'd1;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_ANDI = 5'd2;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_OR   = 5'd3;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_XOR  = 5'd4;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_ADD  = 5'd5;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_ADDI = 5'd6;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_SUB  = 5'd7;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_COMP = 5'd8;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_LT   = 5'd9;
  localparam logic [DEF_OPCODE_SIZE-1:0] OP_EQ   = 5'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // Opcodes this stage is willing to send to the alu; anything else is rejected.
  function automatic logic is_legal_op(input logic [DEF_OPCODE_SIZE-1:0] op);
    case (op)
      OP_NOT, OP_AND, OP_ANDI, OP_OR, OP_XOR, OP_ADD,
      OP_ADDI, OP_SUB, OP_COMP, OP_LT, OP_EQ: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: decoded-instruction valid/ready handshake between the
// decoder (master) and the issue stage (slave).
interface alu_issue_stage_if
  import alu_issue_stage_pkg::*;
#(
  parameter int OPCODE_SIZE   = DEF_OPCODE_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int IMM_SIZE      = DEF_IMM_SIZE
);
  logic                     instr_valid;
  logic                     instr_ready;
  logic [OPCODE_SIZE-1:0]   instr_opcode;
  logic [REG_ADDR_SIZE-1:0] instr_rd;
  logic [REG_ADDR_SIZE-1:0] instr_rs1;
  logic [REG_ADDR_SIZE-1:0] instr_rs2;
  logic [IMM_SIZE-1:0]      instr_imm;

  modport master (
    output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_stage_imm_extend.sv
// alu_issue_stage_imm_extend: widens the immediate field to a full word,
// either sign-extended or zero-extended.
module alu_issue_stage_imm_extend #(
  parameter int IMM_SIZE  = 8,
  parameter int WORD_SIZE = 16
) (
  input  logic [IMM_SIZE-1:0]  imm,
  input  logic                 sign_ext,
  output logic [WORD_SIZE-1:0] imm_ext
);

  // Replicate the immediate's top bit only when sign extension is selected.
  always_comb begin
    imm_ext = {{(WORD_SIZE-IMM_SIZE){sign_ext & imm[IMM_SIZE-1]}}, imm};
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: non-pipelined sequencer feeding the alu. Reads operands
// from the register file, fires the alu for one cycle and writes the result
// back. Optional feature macro: ALU_ISSUE_COUNT_EN adds retired_count.
//
// state | meaning
// IDLE  | ready for an instruction; illegal opcodes are rejected here
// READ  | register-file addresses presented, data arrives next cycle
// EXEC  | alu_enable high, operands taken straight from the rf read data
// WB    | registered alu result written to rd, done pulsed
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int OPCODE_SIZE   = DEF_OPCODE_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int IMM_SIZE      = DEF_IMM_SIZE
) (
  input  logic                     clock,
  input  logic                     reset_n,
  alu_issue_stage_if.slave         instr_if,
  output logic [REG_ADDR_SIZE-1:0] rf_raddr1,
  output logic [REG_ADDR_SIZE-1:0] rf_raddr2,
  input  logic [WORD_SIZE-1:0]     rf_rdata1,
  input  logic [WORD_SIZE-1:0]     rf_rdata2,
  output logic                     rf_we,
  output logic [REG_ADDR_SIZE-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]     rf_wdata,
  output logic [OPCODE_SIZE-1:0]   alu_opcode,
  output logic [WORD_SIZE-1:0]     alu_input1,
  output logic [WORD_SIZE-1:0]     alu_input2,
  output logic                     alu_enable,
  input  logic [WORD_SIZE-1:0]     alu_result,
  output logic                     done,
  output logic                     illegal
`ifdef ALU_ISSUE_COUNT_EN
  ,
  output logic [WORD_SIZE-1:0]     retired_count
`endif
);

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic [OPCODE_SIZE-1:0]   op_q, op_d;
  logic [REG_ADDR_SIZE-1:0] rd_q, rd_d;
  logic [IMM_SIZE-1:0]      imm_q, imm_d;
  logic [REG_ADDR_SIZE-1:0] raddr1_q, raddr1_d;
  logic [REG_ADDR_SIZE-1:0] raddr2_q, raddr2_d;
  logic [OPCODE_SIZE-1:0]   alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0]     in1_q, in1_d;
  logic [WORD_SIZE-1:0]     in2_q, in2_d;
  logic                     alu_en_q, alu_en_d;
  logic                     we_q, we_d;
  logic [REG_ADDR_SIZE-1:0] waddr_q, waddr_d;
  logic [WORD_SIZE-1:0]     wdata_q, wdata_d;
  logic                     done_q, done_d;
  logic                     illegal_q, illegal_d;
`ifdef ALU_ISSUE_COUNT_EN
  logic [WORD_SIZE-1:0]     count_q, count_d;
`endif

  logic [WORD_SIZE-1:0]     imm_ext;
  logic [WORD_SIZE-1:0]     exec_in2;
  logic                     imm_sign;

  assign imm_sign = (op_q == OP_ADDI);

  alu_issue_stage_imm_extend #(
    .IMM_SIZE  (IMM_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) u_imm_extend (
    .imm      (imm_q),
    .sign_ext (imm_sign),
    .imm_ext  (imm_ext)
  );

  // Second alu operand: immediate forms and NOT override the rs2 read data.
  always_comb begin
    exec_in2 = rf_rdata2;
    case (op_q)
      OP_ADDI, OP_ANDI: exec_in2 = imm_ext;
      OP_NOT:           exec_in2 = '0;
      default:          exec_in2 = rf_rdata2;
    endcase
  end

  // Next-state and next-output computation for the four-state sequencer.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    op_d      = op_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    raddr1_d  = raddr1_q;
    raddr2_d  = raddr2_q;
    alu_op_d  = alu_op_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    alu_en_d  = 1'b0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef ALU_ISSUE_COUNT_EN
    count_d   = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (instr_if.instr_valid) begin
          op_d  = instr_if.instr_opcode;
          rd_d  = instr_if.instr_rd;
          imm_d = instr_if.instr_imm;
          if (is_legal_op(instr_if.instr_opcode)) begin
            raddr1_d = instr_if.instr_rs1;
            raddr2_d = instr_if.instr_rs2;
            ready_d  = 1'b0;
            state_d  = READ;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      READ: begin
        alu_en_d = 1'b1;
        alu_op_d = op_q;
        state_d  = EXEC;
      end
      EXEC: begin
        // Remember the operands actually used so they hold after EXEC.
        in1_d   = rf_rdata1;
        in2_d   = exec_in2;
        we_d    = 1'b1;
        done_d  = 1'b1;
        waddr_d = rd_q;
`ifdef ALU_ISSUE_COUNT_EN
        count_d = count_q + WORD_SIZE'(1);
`endif
        state_d = WB;
      end
      WB: begin
        wdata_d = alu_result;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Register all sequencer state; synchronous active-low reset aborts any instruction.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      alu_op_q  <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      alu_en_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_ISSUE_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      raddr1_q  <= raddr1_d;
      raddr2_q  <= raddr2_d;
      alu_op_q  <= alu_op_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      alu_en_q  <= alu_en_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef ALU_ISSUE_COUNT_EN
      count_q   <= count_d;
`endif
    end
  end

  // The rf read data only lands in EXEC and the alu result only in WB, so
  // those operands pass straight through in their cycle and hold otherwise.
  assign alu_input1 = (state_q == EXEC) ? rf_rdata1 : in1_q;
  assign alu_input2 = (state_q == EXEC) ? exec_in2 : in2_q;
  assign rf_wdata   = (state_q == WB) ? alu_result : wdata_q;

  assign instr_if.instr_ready = ready_q;
  assign rf_raddr1  = raddr1_q;
  assign rf_raddr2  = raddr2_q;
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign alu_opcode = alu_op_q;
  assign alu_enable = alu_en_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
`ifdef ALU_ISSUE_COUNT_EN
  assign retired_count = count_q;
`endif

endmodule
